fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register feeding decode_module.
//  Holds the PC and issues word requests to instruction memory with a req/ack handshake.
//  Presents {instr, pc, pc+4, valid} to decode, honours decode-side stall, and flushes on branch/jump redirect.
// PARAMETERS
//  ADDR_W    32             PC / instruction-memory address width
//  RESET_PC  32'h0000_0000  PC value loaded on reset (low 2 bits must be 0)
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous reset, active-high
//  imem_req       out  1       fetch request; held until imem_ack
//  imem_addr      out  ADDR_W  word address of fetch; stable while imem_req=1
//  imem_ack       in   1       memory accepted request and imem_rdata is valid this cycle
//  imem_rdata     in   32      fetched instruction
//  stall_in       in   1       decode/hazard stall: hold IF/ID contents
//  redirect_valid in   1       branch/jump taken: flush and refetch
//  redirect_pc    in   ADDR_W  redirect target; bits [1:0] ignored, forced to 0
//  if_id_valid    out  1       IF/ID register holds a live instruction
//  if_id_instr    out  32      instruction to decode
//  if_id_pc       out  ADDR_W  address of if_id_instr
//  if_id_pc4      out  ADDR_W  if_id_pc + 4, modulo 2^ADDR_W
// BEHAVIOUR
//  Reset (async, rst=1): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC,
//   if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc4=0, skid buffer empty, pending target=0.
//  FSM states: IDLE, FETCH, HOLD, DRAIN.
//  IDLE:  unconditionally -> FETCH on the first clock after rst deasserts.
//  FETCH: imem_req=1, imem_addr=pc.
//   - redirect_valid: pc<=redirect_pc&~3; if_id_valid<=0.
//     If imem_ack=1, data dropped, stay FETCH. If imem_ack=0, -> DRAIN with the target saved.
//   - imem_ack & !stall_in: IF/ID <= {imem_rdata, pc, pc+4}; if_id_valid<=1; pc<=pc+4; stay FETCH.
//   - imem_ack & stall_in: imem_rdata and pc go to the skid buffer; -> HOLD. IF/ID unchanged.
//   - no ack & !stall_in: if_id_valid<=0 (bubble). No ack & stall_in: IF/ID unchanged.
//  HOLD: imem_req=0.
//   - redirect_valid: skid discarded; pc<=target; if_id_valid<=0; -> FETCH.
//   - !stall_in: IF/ID <= skid contents; if_id_valid<=1; pc<=pc+4; -> FETCH.
//   - else: stay HOLD.
//  DRAIN: imem_req=1 with the old address, which stays stable (the handshake cannot be withdrawn).
//   - imem_ack: data dropped; pc<=saved target; -> FETCH.
//   - A further redirect_valid in DRAIN overwrites the saved target.
//   - if_id_valid stays 0.
//  Priority each cycle: rst > redirect_valid > stall_in > imem_ack.
//  Redirect flushes IF/ID even when stall_in=1.
//  Latency: ack at cycle N -> if_id_valid=1 at N+1, unless stalled.
//   Back-to-back acks give one instruction per cycle.
//  PC arithmetic: pc+4 wraps modulo 2^ADDR_W (all-ones-minus-3 -> 0).
//  Stalled IF/ID: instr, pc, pc4 and valid are held bit-exact while stall_in=1.
//  rst asserted mid-request: imem_req drops immediately (async). The stale ack after reset is ignored in IDLE.
// TESTING
//  1 Reset release, imem_ack tied 1: imem_addr 0,4,8,... and if_id_pc=0,4,8 on consecutive cycles.
//    if_id_valid rises one cycle after the first ack.
//  2 Stall: ack on instr @0x8 with stall_in=1 for 3 cycles -> IF/ID holds 0x4 data, imem_req=0.
//    After release, IF/ID=0x8 data, next imem_addr=0xC.
//  3 Redirect with ack the same cycle: redirect_pc=0x103 -> next imem_addr=0x100.
//    if_id_valid=0 for one cycle, then if_id_pc=0x100.
//  4 Redirect while ack withheld 4 cycles: imem_addr stays at the old PC until ack, and that data is dropped.
//    Next imem_addr=target; a second redirect in DRAIN takes effect.
//  5 Redirect in HOLD (stall_in=1): skid discarded, if_id_valid=0.
//    The first valid instruction is from the target.
//  6 Wrap: RESET_PC=32'hFFFF_FFFC -> second fetch address 0, if_id_pc4=0.
//    Assert rst mid-DRAIN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decode-side control
// and the IF/ID register outputs.
interface fetch_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              stall_in;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_id_valid;
  logic [31:0]       if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic [ADDR_W-1:0] if_id_pc4;

  modport master (
    output imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4,
    input  imem_ack, imem_rdata, stall_in, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4,
    output imem_ack, imem_rdata, stall_in, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Issues word fetches
// over a req/ack handshake, parks an accepted word in a skid buffer while
// decode stalls, and flushes/refetches on branch or jump redirect.
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
  logic [ADDR_W-1:0] if_id_pc4_q, if_id_pc4_d;
  logic [ADDR_W-1:0] redir_tgt;
  logic              imem_req;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(4);
  endfunction

  // Redirect targets are always word aligned.
  assign redir_tgt = bus.redirect_pc & ~ADDR_W'(3);

  // Next-state, PC and IF/ID update; priority is redirect > stall > ack.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    target_d      = target_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    imem_req      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Any ack still on the bus from before reset is ignored here.
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (bus.redirect_valid) begin
          if_id_valid_d = 1'b0;
          if (bus.imem_ack) begin
            pc_d = redir_tgt;
          end else begin
            // Request is in flight and cannot be withdrawn: keep its address
            // on the bus and remember where to go once it completes.
            target_d = redir_tgt;
            state_d  = DRAIN;
          end
        end else if (bus.stall_in) begin
          if (bus.imem_ack) begin
            skid_instr_d = bus.imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end
        end else if (bus.imem_ack) begin
          if_id_valid_d = 1'b1;
          if_id_instr_d = bus.imem_rdata;
          if_id_pc_d    = pc_q;
          if_id_pc4_d   = pc_inc(pc_q);
          pc_d          = pc_inc(pc_q);
        end else begin
          if_id_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          if_id_valid_d = 1'b0;
          pc_d          = redir_tgt;
          state_d       = FETCH;
        end else if (!bus.stall_in) begin
          if_id_valid_d = 1'b1;
          if_id_instr_d = skid_instr_q;
          if_id_pc_d    = skid_pc_q;
          if_id_pc4_d   = pc_inc(skid_pc_q);
          pc_d          = pc_inc(pc_q);
          state_d       = FETCH;
        end
      end
      DRAIN: begin
        imem_req      = 1'b1;
        if_id_valid_d = 1'b0;
        if (bus.redirect_valid) begin
          target_d = redir_tgt;
        end
        if (bus.imem_ack) begin
          pc_d    = bus.redirect_valid ? redir_tgt : target_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC, skid and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      target_q      <= '0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      target_q      <= target_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = pc_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_pc4   = if_id_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table walking through streaming,
// stall/skid, redirects (with and without ack), DRAIN and HOLD flushes, plus
// a second instance for PC wrap-around and asynchronous reset mid-DRAIN.
module tb_fetch_stage;

  localparam logic [31:0] K = 32'h1357_9BDF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(32)) ifc0 ();
  fetch_if #(.ADDR_W(32)) ifc1 ();

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut0 (
    .clk (clk), .rst (rst), .bus (ifc0.master)
  );
  fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk (clk), .rst (rst), .bus (ifc1.master)
  );

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ K;
  endfunction

  // Memory model: the instruction word is a fixed function of its address.
  assign ifc0.imem_rdata = ins(ifc0.imem_addr);
  assign ifc1.imem_rdata = ins(ifc1.imem_addr);

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ack, stall, redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc, ipc4, instr;
  } vec_t;

  function automatic vec_t mk(input logic ack, input logic stall, input logic redir,
                              input logic [31:0] rpc, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] ipc, input logic [31:0] ipc4,
                              input logic [31:0] instr);
    vec_t v;
    v.ack = ack; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc; v.ipc4 = ipc4; v.instr = instr;
    return v;
  endfunction

  vec_t tbl[23];

  task automatic check_bus0(input string tag, input vec_t v);
    check({tag, " req"},   {31'd0, ifc0.imem_req},    {31'd0, v.req});
    check({tag, " addr"},  ifc0.imem_addr,            v.addr);
    check({tag, " valid"}, {31'd0, ifc0.if_id_valid}, {31'd0, v.vld});
    check({tag, " pc"},    ifc0.if_id_pc,             v.ipc);
    check({tag, " pc4"},   ifc0.if_id_pc4,            v.ipc4);
    check({tag, " instr"}, ifc0.if_id_instr,          v.instr);
  endtask

  task automatic check_bus1(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] ipc, input logic [31:0] ipc4,
                            input logic [31:0] instr);
    check({tag, " req"},   {31'd0, ifc1.imem_req},    {31'd0, req});
    check({tag, " addr"},  ifc1.imem_addr,            addr);
    check({tag, " valid"}, {31'd0, ifc1.if_id_valid}, {31'd0, vld});
    check({tag, " pc"},    ifc1.if_id_pc,             ipc);
    check({tag, " pc4"},   ifc1.if_id_pc4,            ipc4);
    check({tag, " instr"}, ifc1.if_id_instr,          instr);
  endtask

  initial begin
    // Row: inputs for the coming edge, outputs expected before that edge.
    //               ack stl rdr rpc       req addr        vld ipc       ipc4      instr
    tbl[0]  = mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   32'h0);
    tbl[1]  = mk(1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0,   32'h0);
    tbl[2]  = mk(1, 0, 0, 32'h0,   1, 32'h4,   1, 32'h0,   32'h4,   ins(32'h0));
    tbl[3]  = mk(1, 1, 0, 32'h0,   1, 32'h8,   1, 32'h4,   32'h8,   ins(32'h4));
    tbl[4]  = mk(0, 1, 0, 32'h0,   0, 32'h8,   1, 32'h4,   32'h8,   ins(32'h4));
    tbl[5]  = mk(0, 1, 0, 32'h0,   0, 32'h8,   1, 32'h4,   32'h8,   ins(32'h4));
    tbl[6]  = mk(0, 0, 0, 32'h0,   0, 32'h8,   1, 32'h4,   32'h8,   ins(32'h4));
    tbl[7]  = mk(1, 0, 1, 32'h103, 1, 32'hC,   1, 32'h8,   32'hC,   ins(32'h8));
    tbl[8]  = mk(1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h8,   32'hC,   ins(32'h8));
    tbl[9]  = mk(0, 0, 1, 32'h200, 1, 32'h104, 1, 32'h100, 32'h104, ins(32'h100));
    tbl[10] = mk(0, 0, 1, 32'h302, 1, 32'h104, 0, 32'h100, 32'h104, ins(32'h100));
    tbl[11] = mk(0, 0, 0, 32'h0,   1, 32'h104, 0, 32'h100, 32'h104, ins(32'h100));
    tbl[12] = mk(0, 0, 0, 32'h0,   1, 32'h104, 0, 32'h100, 32'h104, ins(32'h100));
    tbl[13] = mk(1, 0, 0, 32'h0,   1, 32'h104, 0, 32'h100, 32'h104, ins(32'h100));
    tbl[14] = mk(0, 0, 0, 32'h0,   1, 32'h300, 0, 32'h100, 32'h104, ins(32'h100));
    tbl[15] = mk(1, 0, 0, 32'h0,   1, 32'h300, 0, 32'h100, 32'h104, ins(32'h100));
    tbl[16] = mk(1, 1, 0, 32'h0,   1, 32'h304, 1, 32'h300, 32'h304, ins(32'h300));
    tbl[17] = mk(0, 1, 1, 32'h400, 0, 32'h304, 1, 32'h300, 32'h304, ins(32'h300));
    tbl[18] = mk(0, 1, 0, 32'h0,   1, 32'h400, 0, 32'h300, 32'h304, ins(32'h300));
    tbl[19] = mk(1, 0, 0, 32'h0,   1, 32'h400, 0, 32'h300, 32'h304, ins(32'h300));
    tbl[20] = mk(0, 1, 0, 32'h0,   1, 32'h404, 1, 32'h400, 32'h404, ins(32'h400));
    tbl[21] = mk(0, 0, 0, 32'h0,   1, 32'h404, 1, 32'h400, 32'h404, ins(32'h400));
    tbl[22] = mk(0, 0, 0, 32'h0,   1, 32'h404, 0, 32'h400, 32'h404, ins(32'h400));

    rst = 1'b1;
    ifc0.imem_ack = 1'b1;  // stale ack present across reset
    ifc0.stall_in = 1'b0;
    ifc0.redirect_valid = 1'b0;
    ifc0.redirect_pc = '0;
    ifc1.imem_ack = 1'b0;
    ifc1.stall_in = 1'b0;
    ifc1.redirect_valid = 1'b0;
    ifc1.redirect_pc = '0;

    repeat (2) @(negedge clk);
    check_bus0("reset", mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0));
    check_bus1("reset1", 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 32'h0);

    rst = 1'b0;
    for (int i = 0; i < 23; i++) begin
      check_bus0($sformatf("row%0d", i), tbl[i]);
      ifc0.imem_ack       = tbl[i].ack;
      ifc0.stall_in       = tbl[i].stall;
      ifc0.redirect_valid = tbl[i].redir;
      ifc0.redirect_pc    = tbl[i].rpc;
      @(negedge clk);
    end

    // PC wrap on the second instance.
    rst = 1'b1;
    ifc1.imem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_bus1("wrap idle", 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check_bus1("wrap f0", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check_bus1("wrap f1", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0, ins(32'hFFFF_FFFC));
    ifc1.imem_ack       = 1'b0;
    ifc1.redirect_valid = 1'b1;
    ifc1.redirect_pc    = 32'h50;
    @(negedge clk);
    check_bus1("drain", 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h0, ins(32'hFFFF_FFFC));
    ifc1.redirect_valid = 1'b0;

    // Asynchronous reset in the middle of a clock phase while in DRAIN.
    #2 rst = 1'b1;
    #1;
    check_bus1("async rst", 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
